fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of decode. It owns the PC and issues one word-aligned request per cycle to a synchronous instruction memory with 1-cycle read latency. Returned words are buffered with their PC in a small FIFO. The FIFO head is presented to decode over a valid/ready handshake. A redirect from the back end (branch/ROB) flushes all fetched and in-flight work and restarts fetch at a new PC.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request this cycle.
imem_addr  out  32  request address; low 2 bits always 0.
imem_rdata  in  32  instruction word for the request issued in the previous cycle.
redirect_valid  in  1  flush and restart request.
redirect_pc  in  32  restart address; bits [1:0] are ignored (forced to 0).
ready_out  in  1  decode can accept; driven by decode's ready_in.
valid_out  out  1  FIFO head valid; drives decode's valid_in.
instr  out  32  head instruction; drives decode's instr.
pc_out  out  32  head PC; drives decode's pc_in.

Behaviour:
- State: pc_q, pend_q (request outstanding), pend_pc_q, FIFO (rd_ptr, wr_ptr, count).
- Reset (async): pc_q=RESET_PC, pend_q=0, FIFO empty. While reset is high, imem_req=0, imem_addr=RESET_PC, valid_out=0, instr=0, pc_out=0.
- Request condition: imem_req = !reset && !redirect_valid && (count + pend_q < DEPTH). This guarantees every returning word has a free slot, so the FIFO never overflows.
- imem_addr = pc_q at all times, combinational.
- On a request:
  - pc_q <= pc_q + 4, wrapping modulo 2^32.
  - pend_q <= 1 and pend_pc_q <= pc_q.
  - Otherwise pend_q <= 0.
- Push: when pend_q=1 and redirect_valid=0, write {pend_pc_q, imem_rdata} at wr_ptr.
- Pop: when valid_out && ready_out, advance rd_ptr.
- Simultaneous push and pop: count is unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- Output path:
  - valid_out = (count != 0) && !redirect_valid. There is no bypass: the FIFO output is registered.
  - instr and pc_out show the head entry when count != 0, and are 0 when the FIFO is empty.
- Latency: request in cycle t, push at end of t+1, valid_out in t+2.
- Throughput: 1 instruction per cycle while ready_out is held at 1.
- Backpressure: with ready_out=0 the FIFO fills to exactly DEPTH, then imem_req drops. It rises again in the cycle after the first pop.
- Redirect (single-cycle pulse or held):
  - In the redirect cycle: imem_req=0, valid_out=0 (no pop), and the imem_rdata returning this cycle is discarded.
  - At the edge: FIFO cleared (count=0, pointers=0), pend_q<=0, pc_q<=redirect_pc & ~3.
  - If redirect_valid is held, the unit stays flushed.
  - First request to the new PC is in the cycle after redirect deasserts; valid_out follows 2 cycles later.
  - Redirect has priority over push, pop and request in the same cycle.
- Reset asserted mid-operation: all in-flight and buffered instructions are dropped immediately. Fetch restarts at RESET_PC in the first cycle after reset deasserts.
- The output handshake is stable: once valid_out=1 and ready_out=0, instr and pc_out hold until a pop, a redirect or a reset.

Decomposition:
- In types_pkg: add struct fetch_data {pc[31:0], instr[31:0]} and localparam RESET_PC default; decode's inputs are sourced from these fields.
- Sub-module fetch_fifo (parameter DEPTH): storage of fetch_data with push, pop, flush, count, head. fetch_unit keeps PC, pend and request logic.

Test Plan:
- Reset release, ready_out=1, imem model returns 32'h1000_0000|addr -> imem_addr sequence 0,4,8,...; valid_out first high 2 cycles after reset deasserts; pc_out 0,4,8 on consecutive cycles with matching instr.
- ready_out=0 for 10 cycles -> count saturates at 4 (entries PC 0x0–0xC); imem_req=0 afterwards; head holds PC 0x0. Then ready_out=1 -> entries delivered in order with no loss or duplicate.
- redirect_valid pulse with redirect_pc=32'h0000_0203 while 3 entries are buffered and one request is pending -> valid_out=0 that cycle; next cycle imem_addr=0x200; next delivered pc_out=0x200; no stale PC is ever output.
- Redirect coinciding with ready_out=1 and count=1 -> no pop occurs; the entry is discarded; count=0 after the edge.
- Redirect to 32'hFFFF_FFFC -> pc_out sequence FFFF_FFFC, 0000_0000, 0000_0004.
- Async reset asserted mid-stream between clock edges -> valid_out and imem_req drop immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
//
// Contents:
//   DEFAULT_RESET_PC : address of the first fetch after reset
//   fetch_data_t     : one buffered fetch result (PC plus instruction word);
//                      decode's pc_in / instr inputs are sourced from these fields
//   align_word       : clears the two low address bits so every fetch is word-aligned
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small circular buffer of fetch results sitting between the instruction
// memory return path and decode.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : discard every entry; wins over push and pop
//   push, push_pc,
//   push_instr          : write one entry at the tail
//   pop                 : retire the head entry (ignored when empty)
//   count               : current number of valid entries (0..DEPTH)
//   head_pc, head_instr : head entry, forced to zero while empty
//
// The producer is expected never to push into a full buffer; the fetch
// unit's request throttle guarantees this.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [31:0]                push_pc,
  input  logic [31:0]                push_instr,
  input  logic                       pop,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                head_pc,
  output logic [31:0]                head_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_data_t       mem [DEPTH];
  fetch_data_t       head;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;
  logic              not_empty;

  assign not_empty = (count != '0);
  assign do_push   = push && !flush;
  assign do_pop    = pop && not_empty && !flush;

  // Pointers are exactly log2(DEPTH) bits wide, so incrementing past the
  // last slot wraps to zero on its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until count says it is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
    end
  end

  assign head       = mem[rd_ptr];
  assign head_pc    = not_empty ? head.pc    : 32'h0;
  assign head_instr = not_empty ? head.instr : 32'h0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage directly upstream of decode.
//
// Owns the PC and issues one word-aligned read per cycle to a synchronous
// instruction memory with one cycle of read latency. Each returning word is
// paired with the PC that requested it and buffered in fetch_unit_fifo; the
// buffer head is offered to decode over a valid/ready handshake. A redirect
// from the back end drops all buffered and in-flight work and restarts
// fetching at the new PC.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   imem_req       : read request this cycle
//   imem_addr      : read address (always word-aligned, equals the PC)
//   imem_rdata     : word for the request made in the previous cycle
//   redirect_valid : flush and restart (single-cycle pulse or held)
//   redirect_pc    : restart address, low two bits ignored
//   ready_out      : decode can accept this cycle
//   valid_out      : head entry is being offered to decode
//   instr, pc_out  : head instruction and its PC (zero when empty)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ready_out,
  output logic        valid_out,
  output logic [31:0] instr,
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q;
  logic          pend_q;
  logic [31:0]   pend_pc_q;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          push;
  logic          pop;

  // A request is only issued if the slot its data will land in is already
  // guaranteed free, counting the word still on its way back from memory.
  // That is why the buffer can never overflow and needs no full check.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, pend_q};
  assign imem_req  = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
  assign imem_addr = pc_q;

  // The word returning during a redirect belongs to the old stream, so it
  // is not captured.
  assign push = pend_q && !redirect_valid;

  // Gating with redirect keeps decode from taking an entry that is about
  // to be discarded; it also blocks the pop in the flush cycle.
  assign valid_out = (count != '0) && !redirect_valid;
  assign pop       = valid_out && ready_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'h0;
    end else if (redirect_valid) begin
      pc_q   <= align_word(redirect_pc);
      pend_q <= 1'b0;
    end else if (imem_req) begin
      pc_q      <= pc_q + 32'd4;
      pend_q    <= 1'b1;
      pend_pc_q <= pc_q;
    end else begin
      pend_q <= 1'b0;
    end
  end

  fetch_unit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_pc    (pend_pc_q),
    .push_instr (imem_rdata),
    .pop        (pop),
    .count      (count),
    .head_pc    (pc_out),
    .head_instr (instr)
  );

endmodule
